// File: rtl/mem_pkg.sv
// Shared memory-side constants: line geometry, address slice positions and FSM state.
// The cache and flush logic reuse the same index/tag slice definitions.
package mem_pkg;

   localparam int LINE_W   = 256;
   localparam int DEPTH    = 512;
   localparam int INDEX_W  = 9;
   localparam int OFFSET_W = 5;
   localparam int ADDR_W   = 32;

   // Byte address = {tag, index, offset}
   localparam int INDEX_LSB = OFFSET_W;
   localparam int INDEX_MSB = OFFSET_W + INDEX_W - 1;
   localparam int TAG_LSB   = OFFSET_W + INDEX_W;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   function automatic logic [INDEX_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
      return addr[INDEX_MSB:INDEX_LSB];
   endfunction

endpackage

// File: rtl/data_memory_model.sv
// Line-granular main-memory model with fixed access latency and a one-cycle ack.
// One outstanding request; request fields are latched at acceptance and inputs are ignored while busy.
module data_memory_model #(
   parameter int LATENCY = 10,
   parameter int DEPTH   = mem_pkg::DEPTH,
   parameter int LINE_W  = mem_pkg::LINE_W,
   parameter int ADDR_W  = mem_pkg::ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o
);
   import mem_pkg::*;

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   logic [LINE_W-1:0] memory [DEPTH];

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  counter_q, counter_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;

   // Offset and tag bits do not select storage; addresses alias modulo the array size.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[ADDR_W-1:INDEX_LSB+IDX_W], addr_i[INDEX_LSB-1:0]};

   // Decoded purely from flops so the pulse never follows input glitches.
   assign ack_o  = (state_q == BUSY) && (counter_q == CNT_W'(LATENCY - 1));
   assign data_o = (ack_o && !write_q) ? memory[index_q] : '0;

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      index_d   = index_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               index_d   = addr_i[INDEX_LSB +: IDX_W];
               wdata_d   = data_i;
               write_d   = write_i;
               counter_d = '0;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (ack_o) begin
               counter_d = '0;
               state_d   = IDLE;
            end else begin
               counter_d = counter_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         counter_q <= '0;
         index_q   <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         index_q   <= index_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
      end
   end

   // Storage is never reset; an aborted write cannot land because reset forces ack_o low.
   always_ff @(posedge clk_i) begin
      if (ack_o && write_q) memory[index_q] <= wdata_q;
   end

endmodule

// File: tb/tb_data_memory_model.sv
// Scoreboard bench for data_memory_model: expected ack cycle and read data are queued at
// request time and checked when the DUT pulses ack_o.
module tb_data_memory_model;

   localparam int LAT = 10;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  addr_i;
   logic [255:0] data_i;
   logic         enable_i;
   logic         write_i;
   logic         ack_o;
   logic [255:0] data_o;

   data_memory_model #(.LATENCY(LAT)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .ack_o    (ack_o),
      .data_o   (data_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int           cyc;
      logic [255:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Line patterns
   function automatic logic [255:0] pat_m0();
      logic [255:0] l;
      for (int i = 0; i < 16; i++) l[255-16*i -: 16] = {4{4'(i)}};
      return l;
   endfunction
   function automatic logic [255:0] pat_m1();
      logic [255:0] l;
      for (int i = 0; i < 16; i++) l[255-16*i -: 16] = {4{4'(i + 8)}};
      return l;
   endfunction
   function automatic logic [255:0] pat_m32();
      logic [255:0] l;
      for (int i = 0; i < 16; i++) l[255-16*i -: 16] = {4'(i), 8'h00, 4'(i)};
      return l;
   endfunction
   function automatic logic [255:0] pat_m17();
      logic [255:0] l;
      for (int i = 0; i < 16; i++) l[255-16*i -: 16] = {4'h0, 4'(i), 4'(i), 4'h0};
      return l;
   endfunction

   // Monitor: every ack must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (ack_o) begin
         if (sb.size() == 0) begin
            chk("spurious_ack", 256'(ack_o), 256'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_cycle", 256'(cyc), 256'(e.cyc));
            chk("ack_data", data_o, e.data);
         end
      end
   end

   task automatic wait_ack();
      bit ok;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (ack_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("ack_timeout", 256'(0), 256'(1));
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the ack cycle.
   task automatic xfer(input logic [31:0] a, input logic [255:0] d, input logic w,
                       input logic [255:0] expd);
      addr_i   = a;
      data_i   = d;
      write_i  = w;
      enable_i = 1'b1;
      sb.push_back('{cyc + LAT, expd});
      wait_ack();
      enable_i = 1'b0;
      @(negedge clk_i);
      chk("ack_drop", 256'(ack_o), 256'(0));
      chk("data_idle", data_o, 256'(0));
   endtask

   logic [255:0] m0, m1, m2, m16, m17, m32, m33, a5;
   int           n_ack;

   initial begin
      m0  = pat_m0();
      m1  = pat_m1();
      m2  = {16{16'hECFA}};
      m16 = {4{64'h0123_4567_89AB_CDEF}};
      m17 = pat_m17();
      m32 = pat_m32();
      m33 = {8{32'hDEAD_BEEF}};
      a5  = {32{8'hA5}};

      rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
      dut.memory[0]  = m0;
      dut.memory[1]  = m1;
      dut.memory[2]  = m2;
      dut.memory[16] = m16;
      dut.memory[17] = m17;
      dut.memory[32] = m32;
      dut.memory[33] = m33;
      repeat (3) @(negedge clk_i);
      chk("rst_ack", 256'(ack_o), 256'(0));
      chk("rst_data", data_o, 256'(0));
      rst_i = 1'b0;
      @(negedge clk_i);

      // Plain read after reset
      xfer(32'h0000_0000, '0, 1'b0, m0);

      // Write then read back; neighbour untouched
      xfer(32'h0000_0420, a5, 1'b1, 256'(0));
      chk("wr_mem33", dut.memory[33], a5);
      xfer(32'h0000_0420, '0, 1'b0, a5);
      chk("mem32_kept", dut.memory[32], m32);

      // Offset bits ignored, upper bits alias
      xfer(32'h0000_021F, '0, 1'b0, m16);
      xfer(32'h0000_4000, '0, 1'b0, m0);
      xfer(32'hFFFF_C020, '0, 1'b0, m1);

      // Input churn while busy
      addr_i = 32'h0000_0040; write_i = 1'b0; data_i = '1; enable_i = 1'b1;
      sb.push_back('{cyc + LAT, m2});
      repeat (2) @(negedge clk_i);
      addr_i = 32'h0000_0200; write_i = 1'b1;
      wait_ack();
      enable_i = 1'b0; write_i = 1'b0;
      @(negedge clk_i);
      chk("churn_mem16", dut.memory[16], m16);
      chk("churn_mem2", dut.memory[2], m2);

      // Reset mid-write aborts the transaction
      addr_i = 32'h0000_0220; data_i = '1; write_i = 1'b1; enable_i = 1'b1;
      @(negedge clk_i);
      enable_i = 1'b0;
      repeat (4) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0; write_i = 1'b0;
      n_ack = 0;
      repeat (15) begin
         @(negedge clk_i);
         if (ack_o) n_ack++;
      end
      chk("rst_abort_ack", 256'(n_ack), 256'(0));
      chk("rst_abort_mem17", dut.memory[17], m17);
      xfer(32'h0000_0220, '0, 1'b0, m17);

      // Back-to-back reads with enable held
      addr_i = 32'h0000_0000; write_i = 1'b0; enable_i = 1'b1;
      sb.push_back('{cyc + LAT, m0});
      wait_ack();
      addr_i = 32'h0000_0020;
      sb.push_back('{cyc + LAT + 1, m1});
      wait_ack();
      enable_i = 1'b0;
      @(negedge clk_i);
      chk("b2b_drop", 256'(ack_o), 256'(0));

      repeat (3) @(negedge clk_i);
      chk("sb_empty", 256'(sb.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
